// File: rtl/ps2_pkg.sv
// PS/2 keyboard shared types and scan-code constants.
// Latency: n/a (package only).
// Backpressure: none.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } frame_state_t;

    localparam logic [7:0] PS2_EXT       = 8'hE0;
    localparam logic [7:0] PS2_BRK       = 8'hF0;
    localparam logic [7:0] CAPS_CODE_DEF = 8'h58;

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 serial frame receiver: sync, clock filter, 11-bit frame FSM, parity check, watchdog.
// Latency: rx_valid/frame_err one clk after the stop-bit fall_stb cycle.
// Backpressure: none; the consumer must accept rx_valid whenever it pulses.
// Ports: clk, rst_n, ps2_clk/ps2_data (raw pins) -> rx_valid, rx_byte, frame_err, busy.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int FILT_LEN = 4,
    parameter int TIMEOUT  = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err,
    output logic       busy
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [1:0]          clk_sync;
    logic [1:0]          data_sync;
    logic [FILT_LEN-1:0] filt_sr;
    logic                filt_clk;
    logic                filt_clk_d;
    logic                fall_stb;
    logic                data_bit;
    logic                timeout;
    frame_state_t        state;
    logic [2:0]          bitcnt;
    logic [7:0]          shreg;
    logic                par_bit;
    logic [TW-1:0]       timer;

    assign fall_stb = filt_clk_d & ~filt_clk;
    assign data_bit = data_sync[1];
    assign busy     = (state != IDLE);
    // A falling edge arriving in the timeout cycle keeps the frame alive.
    assign timeout  = (state != IDLE) && !fall_stb && (timer == TW'(TIMEOUT));

    // Synchronisers and clock filter; idle-high line so everything resets to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync   <= 2'b11;
            data_sync  <= 2'b11;
            filt_sr    <= '1;
            filt_clk   <= 1'b1;
            filt_clk_d <= 1'b1;
        end else begin
            clk_sync   <= {clk_sync[0], ps2_clk};
            data_sync  <= {data_sync[0], ps2_data};
            filt_sr    <= {filt_sr[FILT_LEN-2:0], clk_sync[1]};
            // Hysteresis: only a unanimous window changes the filtered clock.
            if (&filt_sr) begin
                filt_clk <= 1'b1;
            end else if (filt_sr == '0) begin
                filt_clk <= 1'b0;
            end
            filt_clk_d <= filt_clk;
        end
    end

    // Watchdog: measures the gap since the last falling edge inside a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (fall_stb || state == IDLE) begin
            timer <= '0;
        end else if (timer != TW'(TIMEOUT)) begin
            timer <= timer + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bitcnt    <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            rx_valid  <= 1'b0;
            rx_byte   <= '0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (timeout) begin
                state     <= IDLE;
                frame_err <= 1'b1;
            end else if (fall_stb) begin
                case (state)
                    IDLE: begin
                        if (!data_bit) begin
                            state  <= DATA;
                            bitcnt <= '0;
                        end
                    end
                    DATA: begin
                        shreg  <= {data_bit, shreg[7:1]};
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        par_bit <= data_bit;
                        state   <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        // Odd parity over data+parity and a high stop bit.
                        if (data_bit && (^{par_bit, shreg})) begin
                            rx_valid <= 1'b1;
                            rx_byte  <= shreg;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard controller: frame receive plus scan-code decode with hardware Caps Lock.
// Latency: intp/ps2_byte/ext_key/caps_flg update 2 clk after the stop-bit fall_stb cycle.
// Backpressure: none; frames arrive far slower than the 2-cycle decode path.
// Ports: clk, rst_n, ps2_clk, ps2_data -> ps2_byte, ext_key, caps_flg, intp, frame_err, busy.
module ps2_kbd_ctrl
    import ps2_pkg::*;
#(
    parameter int         FILT_LEN  = 4,
    parameter int         TIMEOUT   = 50000,
    parameter logic [7:0] CAPS_CODE = CAPS_CODE_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] ps2_byte,
    output logic       ext_key,
    output logic       caps_flg,
    output logic       intp,
    output logic       frame_err,
    output logic       busy
);

    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       brk;
    logic       ext;
    logic       caps_held;

    ps2_rx_frame #(
        .FILT_LEN (FILT_LEN),
        .TIMEOUT  (TIMEOUT)
    ) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps2_byte  <= '0;
            ext_key   <= 1'b0;
            caps_flg  <= 1'b0;
            intp      <= 1'b0;
            brk       <= 1'b0;
            ext       <= 1'b0;
            caps_held <= 1'b0;
        end else begin
            intp <= 1'b0;
            if (rx_valid) begin
                if (rx_byte == PS2_EXT) begin
                    ext <= 1'b1;
                end else if (rx_byte == PS2_BRK) begin
                    brk <= 1'b1;
                end else if (brk) begin
                    brk <= 1'b0;
                    ext <= 1'b0;
                    if (rx_byte == CAPS_CODE && !ext) begin
                        caps_held <= 1'b0;
                    end
                end else begin
                    ps2_byte <= rx_byte;
                    ext_key  <= ext;
                    intp     <= 1'b1;
                    ext      <= 1'b0;
                    // caps_held masks typematic repeats until the key is released.
                    if (rx_byte == CAPS_CODE && !ext && !caps_held) begin
                        caps_flg  <= ~caps_flg;
                        caps_held <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Self-checking bench for ps2_kbd_ctrl: directed key sequences plus random frames vs a byte-level model.
// Latency: intp expected a fixed small window after the stop-bit falling edge.
// Backpressure: n/a.
module tb_ps2_kbd_ctrl;

    localparam int         FL   = 4;
    localparam int         TO   = 500;
    localparam int         HALF = 20;
    localparam logic [7:0] CAPS = 8'h58;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] ps2_byte;
    logic       ext_key;
    logic       caps_flg;
    logic       intp;
    logic       frame_err;
    logic       busy;

    ps2_kbd_ctrl #(
        .FILT_LEN  (FL),
        .TIMEOUT   (TO),
        .CAPS_CODE (CAPS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .ps2_byte  (ps2_byte),
        .ext_key   (ext_key),
        .caps_flg  (caps_flg),
        .intp      (intp),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int tests    = 0;
    int fails    = 0;
    int cyc      = 0;
    int intp_cnt = 0;
    int err_cnt  = 0;
    int intp_cyc = 0;
    int fall_cyc = 0;

    // Reference model state: what a keyboard host would track per scan code.
    bit         m_brk, m_ext, m_held, m_caps, m_extkey;
    logic [7:0] m_byte;

    always @(negedge clk) begin
        cyc++;
        if (intp) begin
            intp_cnt++;
            intp_cyc = cyc;
        end
        if (frame_err) err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_brk = 0; m_ext = 0; m_held = 0; m_caps = 0; m_extkey = 0; m_byte = 8'h00;
    endtask

    task automatic model_code(input logic [7:0] c);
        if (c == 8'hE0) m_ext = 1;
        else if (c == 8'hF0) m_brk = 1;
        else if (m_brk) begin
            if (c == CAPS && !m_ext) m_held = 0;
            m_brk = 0;
            m_ext = 0;
        end else begin
            if (c == CAPS && !m_ext && !m_held) begin
                m_caps = !m_caps;
                m_held = 1;
            end
            m_byte   = c;
            m_extkey = m_ext;
            m_ext    = 0;
        end
    endtask

    task automatic ps2_bit(input bit b);
        ps2_data = b;
        tick(HALF / 2);
        ps2_clk  = 1'b0;
        fall_cyc = cyc;
        tick(HALF);
        ps2_clk  = 1'b1;
        tick(HALF / 2);
    endtask

    task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit stop);
        bit par;
        par = ~(^code) ^ bad_par;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(code[i]);
        ps2_bit(par);
        ps2_bit(stop);
    endtask

    task automatic frame_check(input string tag, input logic [7:0] code, input bit bad_par, input bit stop);
        int i0, e0, lat;
        bit ok, make;
        i0   = intp_cnt;
        e0   = err_cnt;
        ok   = !bad_par && stop;
        make = ok && code != 8'hE0 && code != 8'hF0 && !m_brk;
        send_frame(code, bad_par, stop);
        tick(20);
        if (ok) model_code(code);
        chk({tag, ".intp"}, intp_cnt - i0, {31'd0, make});
        chk({tag, ".ferr"}, err_cnt - e0, {31'd0, !ok});
        if (make) begin
            lat = intp_cyc - fall_cyc;
            chk({tag, ".lat_in_window"}, {31'd0, (lat >= FL + 4 && lat <= FL + 8)}, 1);
        end
        chk({tag, ".byte"}, ps2_byte, m_byte);
        chk({tag, ".ext_key"}, ext_key, m_extkey);
        chk({tag, ".caps"}, caps_flg, m_caps);
        chk({tag, ".busy"}, busy, 0);
    endtask

    initial begin
        int e0, i0, busy_seen, n;
        logic [7:0] pool [7];
        model_reset();
        pool = '{8'h1C, 8'h32, 8'h58, 8'h75, 8'hE0, 8'hF0, 8'h12};

        tick(5);
        chk("reset.outs", {ps2_byte, ext_key, caps_flg, intp, frame_err, busy}, 0);
        rst_n = 1'b1;
        tick(10);

        // Single make code.
        frame_check("make1c", 8'h1C, 0, 1);
        // Break sequence must not disturb the held make.
        frame_check("brk_f0", 8'hF0, 0, 1);
        frame_check("brk_1c", 8'h1C, 0, 1);
        chk("brk.byte_held", ps2_byte, 8'h1C);

        // Short low glitch while idle must not start a frame.
        i0 = intp_cnt; e0 = err_cnt; busy_seen = 0;
        ps2_clk = 1'b0;
        tick(FL - 1);
        ps2_clk = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (busy) busy_seen = 1;
            tick(1);
        end
        chk("glitch.busy", busy_seen, 0);
        chk("glitch.events", (intp_cnt - i0) + (err_cnt - e0), 0);

        // Caps Lock with typematic repeats and release.
        i0 = intp_cnt;
        frame_check("caps_a", 8'h58, 0, 1);
        frame_check("caps_b", 8'h58, 0, 1);
        frame_check("caps_c", 8'h58, 0, 1);
        frame_check("caps_f0", 8'hF0, 0, 1);
        frame_check("caps_rel", 8'h58, 0, 1);
        chk("caps.on", caps_flg, 1);
        chk("caps.intp3", intp_cnt - i0, 3);
        frame_check("caps_again", 8'h58, 0, 1);
        chk("caps.off", caps_flg, 0);

        // Extended keys.
        frame_check("ext_e0", 8'hE0, 0, 1);
        frame_check("ext_75", 8'h75, 0, 1);
        chk("ext.key", {ps2_byte, 7'd0, ext_key}, {8'h75, 8'h01});
        frame_check("extb_e0", 8'hE0, 0, 1);
        frame_check("extb_f0", 8'hF0, 0, 1);
        frame_check("extb_75", 8'h75, 0, 1);
        frame_check("ext_clr", 8'h1C, 0, 1);
        chk("ext.cleared", ext_key, 0);

        // Parity and stop errors, then recovery.
        frame_check("bad_par", 8'h1C, 1, 1);
        frame_check("bad_stop", 8'h1C, 0, 0);
        frame_check("recover", 8'h32, 0, 1);
        chk("recover.byte", ps2_byte, 8'h32);

        // Watchdog abort after 4 data bits.
        i0 = intp_cnt; e0 = err_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        chk("to.busy_mid", busy, 1);
        n = 0;
        while (err_cnt == e0 && n < TO + 200) begin
            tick(1);
            n++;
        end
        tick(2);
        chk("to.ferr", err_cnt - e0, 1);
        chk("to.busy", busy, 0);
        chk("to.no_intp", intp_cnt - i0, 0);
        frame_check("to_next", 8'h1C, 0, 1);

        // Turn Caps on, then reset in the middle of a frame.
        frame_check("pre_f0", 8'hF0, 0, 1);
        frame_check("pre_rel", 8'h58, 0, 1);
        frame_check("pre_on", 8'h58, 0, 1);
        chk("pre.caps", caps_flg, 1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid.outs", {ps2_byte, ext_key, caps_flg, intp, frame_err, busy}, 0);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        tick(5);
        rst_n = 1'b1;
        model_reset();
        tick(20);
        frame_check("post_rst", 8'h32, 0, 1);

        // Random traffic against the model.
        for (int k = 0; k < 40; k++) begin
            logic [7:0] c;
            bit bp, st;
            c  = pool[$urandom_range(0, 6)];
            bp = 0;
            st = 1;
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 0) bp = 1;
                else st = 0;
            end
            frame_check($sformatf("rnd%0d", k), c, bp, st);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
